interrupt_control_8259a: RTL

- Sequencing controller for the 8259A priority resolver. It owns the in-service register (ISR) and the priority rotation state that it feeds to the resolver.
- Consumes the resolver's one-hot `interrupt` request. Drives INT, runs the 8086-mode two-pulse INTA acknowledge, emits the vector byte, and executes OCW2 EOI/rotate commands.
- Sits between the resolver, the IRR block and the bus/control-word decoder.

---
 rtl/pic8259_pkg.sv | 47 ++++
 rtl/isr_priority_scan.sv | 21 ++
 rtl/interrupt_control_8259a.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pic8259_pkg.sv
// Shared types, OCW2 command codes and bit helpers for the 8259A sequencing controller.
package pic8259_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } pic_state_e;

    localparam logic [2:0] OCW2_AROT_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI   = 3'b001;
    localparam logic [2:0] OCW2_NOP      = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI   = 3'b011;
    localparam logic [2:0] OCW2_AROT_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI  = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP   = 3'b111;

    // Bit n moves to bit 0.
    function automatic logic [7:0] rotate_right8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} >> n;
        return d[7:0];
    endfunction

    // Bit 0 moves to bit n.
    function automatic logic [7:0] rotate_left8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [2:0] onehot_to_bin3(input logic [7:0] v);
        logic [2:0] b;
        b = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) b = b | 3'(i);
        end
        return b;
    endfunction

    function automatic logic [7:0] bin3_to_onehot(input logic [2:0] b);
        return 8'd1 << b;
    endfunction

endpackage

// File: rtl/isr_priority_scan.sv
// Highest-priority in-service bit under rotation: rotate, pick lowest set bit, un-rotate.
module isr_priority_scan
    import pic8259_pkg::*;
(
    input  logic [7:0] isr,
    input  logic [2:0] priority_rotate,
    output logic [7:0] highest_level_in_service
);

    logic [2:0] start;
    logic [7:0] rotated;
    logic [7:0] lowest;

    always_comb begin
        start   = 3'(priority_rotate + 3'd1);
        rotated = rotate_right8(isr, start);
        lowest  = rotated & 8'(~rotated + 8'd1);
        highest_level_in_service = rotate_left8(lowest, start);
    end

endmodule

// File: rtl/interrupt_control_8259a.sv
// 8259A ISR / rotation owner: INT, two-pulse INTA acknowledge, vector byte and OCW2 EOI/rotate.
// Optional poll command compiled in with PIC8259_POLL_MODE_EN.
module interrupt_control_8259a
    import pic8259_pkg::*;
#(
    parameter logic [4:0] VECTOR_DEFAULT = 5'b00000
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       inta_start,
    input  logic       inta_end,
`ifdef PIC8259_POLL_MODE_EN
    input  logic       poll_cmd,
`endif
    input  logic [4:0] vector_base,
    input  logic       auto_eoi_config,
    input  logic       ocw2_write,
    input  logic [2:0] ocw2_cmd,
    input  logic [2:0] ocw2_level,
    output logic       int_out,
    output logic [7:0] clear_irr,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    pic_state_e state_q, state_d;
    logic [2:0] level_q, level_d;
    logic       auto_rotate_q, auto_rotate_d;
    logic [4:0] vbase_q, vbase_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] rot_q, rot_d;
    logic       int_q, int_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;
    logic       skip_aeoi_q, skip_aeoi_d;

    logic [7:0] hlis;
    logic [2:0] hlis_bin;
    logic       irq_any;
    logic [2:0] irq_level;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;

    isr_priority_scan u_scan (
        .isr                      (isr_q),
        .priority_rotate          (rot_q),
        .highest_level_in_service (hlis)
    );

    assign hlis_bin  = onehot_to_bin3(hlis);
    assign irq_any   = |interrupt;
    assign irq_level = irq_any ? onehot_to_bin3(interrupt) : 3'd7;

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        auto_rotate_d = auto_rotate_q;
        vbase_d       = vbase_q;
        rot_d         = rot_q;
        int_d         = int_q;
        clear_irr_d   = 8'h00;
        data_d        = data_q;
        en_d          = en_q;
        skip_aeoi_d   = skip_aeoi_q;
        isr_set       = 8'h00;
        isr_clr       = 8'h00;

        case (state_q)
            ST_IDLE: begin
                vbase_d = vector_base;
                int_d   = irq_any;
                if (inta_start) begin
                    state_d     = ST_ACK1;
                    int_d       = 1'b1;
                    level_d     = irq_level;
                    skip_aeoi_d = !irq_any;
                    isr_set     = interrupt;
                    clear_irr_d = interrupt;
                end
`ifdef PIC8259_POLL_MODE_EN
                else if (poll_cmd) begin
                    state_d     = ST_ACK2;
                    int_d       = 1'b0;
                    level_d     = irq_level;
                    skip_aeoi_d = 1'b1;
                    isr_set     = interrupt;
                    clear_irr_d = interrupt;
                    data_d      = {irq_any, 4'b0000, irq_level};
                    en_d        = 1'b1;
                end
`endif
            end
            ST_ACK1: begin
                if (inta_end) begin
                    state_d = ST_WAIT2;
                    int_d   = 1'b0;
                end
            end
            ST_WAIT2: begin
                if (inta_start) begin
                    state_d = ST_ACK2;
                    data_d  = {vbase_q, level_q};
                    en_d    = 1'b1;
                end
            end
            ST_ACK2: begin
                if (inta_end) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    if (auto_eoi_config && !skip_aeoi_q) begin
                        isr_clr = bin3_to_onehot(level_q);
                        if (auto_rotate_q) rot_d = level_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // OCW2 is evaluated after AEOI so its rotate value takes precedence.
        if (ocw2_write) begin
            case (ocw2_cmd)
                OCW2_NS_EOI: isr_clr = isr_clr | hlis;
                OCW2_SP_EOI: isr_clr = isr_clr | bin3_to_onehot(ocw2_level);
                OCW2_ROT_NS: begin
                    if (isr_q != 8'h00) begin
                        isr_clr = isr_clr | hlis;
                        rot_d   = hlis_bin;
                    end
                end
                OCW2_ROT_SP: begin
                    isr_clr = isr_clr | bin3_to_onehot(ocw2_level);
                    rot_d   = ocw2_level;
                end
                OCW2_SET_PRI:  rot_d = ocw2_level;
                OCW2_AROT_SET: auto_rotate_d = 1'b1;
                OCW2_AROT_CLR: auto_rotate_d = 1'b0;
                default: ;
            endcase
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            level_q       <= 3'd0;
            auto_rotate_q <= 1'b0;
            vbase_q       <= VECTOR_DEFAULT;
            isr_q         <= 8'h00;
            rot_q         <= 3'b111;
            int_q         <= 1'b0;
            clear_irr_q   <= 8'h00;
            data_q        <= 8'h00;
            en_q          <= 1'b0;
            skip_aeoi_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            auto_rotate_q <= auto_rotate_d;
            vbase_q       <= vbase_d;
            isr_q         <= isr_d;
            rot_q         <= rot_d;
            int_q         <= int_d;
            clear_irr_q   <= clear_irr_d;
            data_q        <= data_d;
            en_q          <= en_d;
            skip_aeoi_q   <= skip_aeoi_d;
        end
    end

    assign int_out                  = int_q;
    assign clear_irr                = clear_irr_q;
    assign in_service_register      = isr_q;
    assign highest_level_in_service = hlis;
    assign priority_rotate          = rot_q;
    assign data_out                 = data_q;
    assign data_out_en              = en_q;

endmodule
